// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: opcodes, predictor-update
// kinds and the update-queue entry layout.
package branch_resolve_pkg;

  localparam logic [3:0] OP_JIRL = 4'b0011;
  localparam logic [3:0] OP_B    = 4'b0100;
  localparam logic [3:0] OP_BL   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_BGE  = 4'b1001;
  localparam logic [3:0] OP_BLTU = 4'b1010;
  localparam logic [3:0] OP_BGEU = 4'b1011;

  localparam logic [1:0] KIND_COND     = 2'd0;
  localparam logic [1:0] KIND_DIRECT   = 2'd1;
  localparam logic [1:0] KIND_CALL     = 2'd2;
  localparam logic [1:0] KIND_INDIRECT = 2'd3;

  // Entry layout at the default address width; the top module keeps the same
  // field order {pc, target, taken, kind} for any ADDR_WIDTH.
  localparam int BR_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [BR_ADDR_WIDTH-1:0] pc;
    logic [BR_ADDR_WIDTH-1:0] target;
    logic                     taken;
    logic [1:0]               kind;
  } upd_entry_t;

endpackage

// File: rtl/branch_upd_fifo.sv
// Predictor-update FIFO: extra-bit pointers for full/empty, registered count,
// head forced to zero while empty.
module branch_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] COUNT_FULL = DEPTH[PW:0];

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_en;
  logic             pop_en;
  logic             full;

  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_valid = (wr_ptr != rd_ptr);
  assign push_en    = push && !full;
  assign pop_en     = pop && head_valid;
  assign head_data  = head_valid ? mem[rd_ptr[PW-1:0]] : {WIDTH{1'b0}};

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {(PW+1){1'b0}};
      rd_ptr <= {(PW+1){1'b0}};
      count  <= {(PW+1){1'b0}};
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_en, pop_en})
        2'b10:   count <= (count < COUNT_FULL) ? count + PTR_ONE : count;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with registered results and an in-order
// predictor-update queue. Optional counters: BRANCH_RESOLVE_PERF_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int UPD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_kill,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_pc_next,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [ADDR_WIDTH-1:0] in_sr0,
  input  logic [ADDR_WIDTH-1:0] in_sr1,
  input  logic [ADDR_WIDTH-1:0] in_imm,
  input  logic [1:0]            in_category,
  output logic                  out_valid,
  output logic                  out_rd_en,
  output logic [4:0]            out_rd_addr,
  output logic [ADDR_WIDTH-1:0] out_rd_data,
  output logic                  out_taken,
  output logic [ADDR_WIDTH-1:0] out_target,
  output logic                  out_flush,
  output logic [1:0]            out_category,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  upd_taken,
  output logic [1:0]            upd_kind
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
`endif
);

  localparam int ENTRY_W = 2 * ADDR_WIDTH + ($bits(upd_entry_t) - 2 * BR_ADDR_WIDTH);
  localparam int CW = $clog2(UPD_DEPTH) + 1;
  localparam logic [CW-1:0] COUNT_FULL = UPD_DEPTH[CW-1:0];

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] target;
  logic                  taken;
  logic                  is_jirl;
  logic                  valid_op;
  logic                  link;
  logic [4:0]            link_addr;
  logic [1:0]            kind;
  logic                  accept;
  logic                  push;
  logic [CW-1:0]         upd_count;
  logic [ENTRY_W-1:0]    head_data;

  assign pc_plus4 = in_pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  assign offset   = {in_imm[ADDR_WIDTH-3:0], 2'b00};
  assign in_ready = (upd_count < COUNT_FULL);
  assign accept   = in_valid && in_ready && !in_kill;
  assign push     = accept && valid_op;

  // Decode direction, link and predictor kind from the opcode.
  always_comb begin
    taken     = 1'b0;
    is_jirl   = 1'b0;
    valid_op  = 1'b1;
    link      = 1'b0;
    link_addr = 5'd0;
    kind      = KIND_COND;
    case (in_op)
      OP_JIRL: begin
        taken     = 1'b1;
        is_jirl   = 1'b1;
        link      = (in_rd != 5'd0);
        link_addr = in_rd;
        kind      = (in_rd == 5'd1) ? KIND_CALL : KIND_INDIRECT;
      end
      OP_B: begin
        taken = 1'b1;
        kind  = KIND_DIRECT;
      end
      OP_BL: begin
        taken     = 1'b1;
        link      = 1'b1;
        link_addr = 5'd1;
        kind      = KIND_CALL;
      end
      OP_BEQ:  taken = (in_sr0 == in_sr1);
      OP_BNE:  taken = (in_sr0 != in_sr1);
      OP_BLT:  taken = ($signed(in_sr0) < $signed(in_sr1));
      OP_BGE:  taken = ($signed(in_sr0) >= $signed(in_sr1));
      OP_BLTU: taken = (in_sr0 < in_sr1);
      OP_BGEU: taken = (in_sr0 >= in_sr1);
      default: valid_op = 1'b0;
    endcase
  end

  // Resolved next pc; all sums wrap at the address width.
  always_comb begin
    target = pc_plus4;
    if (!taken) begin
      target = pc_plus4;
    end else if (is_jirl) begin
      target = in_sr1 + offset;
    end else begin
      target = in_pc + offset;
    end
  end

  // Result register: one-cycle pulse, enables gated, data held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rd_en    <= 1'b0;
      out_rd_addr  <= 5'd0;
      out_rd_data  <= {ADDR_WIDTH{1'b0}};
      out_taken    <= 1'b0;
      out_target   <= {ADDR_WIDTH{1'b0}};
      out_flush    <= 1'b0;
      out_category <= 2'd0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rd_en    <= link;
      out_rd_addr  <= link_addr;
      out_rd_data  <= pc_plus4;
      out_taken    <= taken;
      out_target   <= target;
      out_flush    <= (target != in_pc_next);
      out_category <= in_category;
    end else begin
      out_valid <= 1'b0;
      out_rd_en <= 1'b0;
      out_flush <= 1'b0;
    end
  end

  branch_upd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({in_pc, target, taken, kind}),
    .pop        (upd_ready),
    .head_valid (upd_valid),
    .head_data  (head_data),
    .count      (upd_count)
  );

  assign {upd_pc, upd_target, upd_taken, upd_kind} = head_data;

`ifdef BRANCH_RESOLVE_PERF_EN
  // Event counters, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else begin
      if (push) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (out_flush) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: fixed vectors, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_branch_resolve;

  localparam int AW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_kill;
  logic [AW-1:0] in_pc, in_pc_next, in_sr0, in_sr1, in_imm;
  logic [3:0]    in_op;
  logic [4:0]    in_rd;
  logic [1:0]    in_category;
  logic          out_valid, out_rd_en, out_taken, out_flush;
  logic [4:0]    out_rd_addr;
  logic [AW-1:0] out_rd_data, out_target;
  logic [1:0]    out_category;
  logic          upd_valid, upd_ready, upd_taken;
  logic [AW-1:0] upd_pc, upd_target;
  logic [1:0]    upd_kind;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0]   perf_branches, perf_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.ADDR_WIDTH(AW), .UPD_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kill(in_kill),
    .in_pc(in_pc), .in_pc_next(in_pc_next), .in_op(in_op), .in_rd(in_rd),
    .in_sr0(in_sr0), .in_sr1(in_sr1), .in_imm(in_imm), .in_category(in_category),
    .out_valid(out_valid), .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr),
    .out_rd_data(out_rd_data), .out_taken(out_taken), .out_target(out_target),
    .out_flush(out_flush), .out_category(out_category),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_kind(upd_kind)
`ifdef BRANCH_RESOLVE_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          taken;
    logic [AW-1:0] target;
    logic          rd_en;
    logic [4:0]    rd_addr;
    logic [1:0]    kind;
    logic          push;
  } ref_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          taken;
    logic [1:0]    kind;
  } ent_t;

  function automatic ref_t ref_resolve(input logic [3:0] op, input logic [AW-1:0] pc,
                                       input logic [4:0] rd, input logic [AW-1:0] a,
                                       input logic [AW-1:0] b, input logic [AW-1:0] imm);
    ref_t r;
    r.taken = 1'b0; r.rd_en = 1'b0; r.rd_addr = 5'd0; r.kind = 2'd0; r.push = 1'b1;
    case (op)
      4'd3:  begin r.taken = 1'b1; r.rd_en = (rd != 5'd0); r.rd_addr = rd;
                   r.kind = (rd == 5'd1) ? 2'd2 : 2'd3; end
      4'd4:  begin r.taken = 1'b1; r.kind = 2'd1; end
      4'd5:  begin r.taken = 1'b1; r.kind = 2'd2; r.rd_en = 1'b1; r.rd_addr = 5'd1; end
      4'd6:  r.taken = (a == b);
      4'd7:  r.taken = (a != b);
      4'd8:  r.taken = ($signed(a) < $signed(b));
      4'd9:  r.taken = ($signed(a) >= $signed(b));
      4'd10: r.taken = (a < b);
      4'd11: r.taken = (a >= b);
      default: r.push = 1'b0;
    endcase
    if (!r.taken)        r.target = pc + 32'd4;
    else if (op == 4'd3) r.target = b + imm * 32'd4;
    else                 r.target = pc + imm * 32'd4;
    return r;
  endfunction

  ent_t          mq[$];
  ref_t          mr;
  logic          macc;
  logic          e_valid, e_rd_en, e_taken, e_flush;
  logic [4:0]    e_rd_addr;
  logic [AW-1:0] e_rd_data, e_target;
  logic [1:0]    e_cat;
  logic [31:0]   e_perf_br, e_perf_mis;
  ent_t          e_head;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      e_valid = 1'b0; e_rd_en = 1'b0; e_taken = 1'b0; e_flush = 1'b0;
      e_rd_addr = 5'd0; e_rd_data = '0; e_target = '0; e_cat = 2'd0;
      e_perf_br = 32'd0; e_perf_mis = 32'd0;
    end else begin
      mr   = ref_resolve(in_op, in_pc, in_rd, in_sr0, in_sr1, in_imm);
      macc = in_valid && (mq.size() < D) && !in_kill;
      if (e_flush) e_perf_mis = e_perf_mis + 32'd1;
      if (mq.size() > 0 && upd_ready) void'(mq.pop_front());
      if (macc) begin
        e_valid = 1'b1; e_rd_en = mr.rd_en; e_rd_addr = mr.rd_addr;
        e_rd_data = in_pc + 32'd4; e_taken = mr.taken; e_target = mr.target;
        e_flush = (mr.target != in_pc_next); e_cat = in_category;
        if (mr.push) begin
          mq.push_back('{pc: in_pc, target: mr.target, taken: mr.taken, kind: mr.kind});
          e_perf_br = e_perf_br + 32'd1;
        end
      end else begin
        e_valid = 1'b0; e_rd_en = 1'b0; e_flush = 1'b0;
      end
    end
  end

  // Compare every observable output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out",
            {out_valid, out_rd_en, out_rd_addr, out_rd_data, out_taken, out_target, out_flush, out_category},
            {e_valid, e_rd_en, e_rd_addr, e_rd_data, e_taken, e_target, e_flush, e_cat});
      check("model_in_ready", in_ready, (mq.size() < D));
      e_head = (mq.size() > 0) ? mq[0] : '0;
      check("model_upd", {upd_valid, upd_pc, upd_target, upd_taken, upd_kind},
            {(mq.size() > 0), e_head});
`ifdef BRANCH_RESOLVE_PERF_EN
      check("model_perf", {perf_branches, perf_mispredicts}, {e_perf_br, e_perf_mis});
`endif
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] pc, pc_next, sr0, sr1, imm;
    logic [4:0]    rd;
    logic          x_taken;
    logic [AW-1:0] x_target;
    logic          x_flush, x_rd_en;
    logic [4:0]    x_rd_addr;
    logic [AW-1:0] x_rd_data;
    logic          x_push;
    logic [1:0]    x_kind;
  } vec_t;

  vec_t vt[10];
  logic [3:0] op_pool[11] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd15};

  task automatic drive_idle();
    in_valid = 1'b0; in_kill = 1'b0; in_op = 4'd0; in_rd = 5'd0; in_pc = '0;
    in_pc_next = '0; in_sr0 = '0; in_sr1 = '0; in_imm = '0; in_category = 2'd0;
  endtask

  initial begin
    rst = 1'b1; upd_ready = 1'b1;
    drive_idle();
    //                op     pc            pc_next       sr0           sr1           imm           rd     tk    target        fl    rden  rda    rd_data       push  kind
    vt[0] = '{4'd6,  32'h100,      32'h104,      32'd5,        32'd5,        32'd4,        5'd0, 1'b1, 32'h110,      1'b1, 1'b0, 5'd0, 32'h104,      1'b1, 2'd0};
    vt[1] = '{4'd5,  32'h200,      32'h1F8,      32'd0,        32'd0,        32'hFFFFFFFE, 5'd9, 1'b1, 32'h1F8,      1'b0, 1'b1, 5'd1, 32'h204,      1'b1, 2'd2};
    vt[2] = '{4'd3,  32'h300,      32'h4,        32'd0,        32'hFFFFFFFC, 32'd2,        5'd0, 1'b1, 32'h4,        1'b0, 1'b0, 5'd0, 32'h304,      1'b1, 2'd3};
    vt[3] = '{4'd8,  32'h400,      32'h404,      32'hFFFFFFFF, 32'd1,        32'd8,        5'd0, 1'b1, 32'h420,      1'b1, 1'b0, 5'd0, 32'h404,      1'b1, 2'd0};
    vt[4] = '{4'd10, 32'h400,      32'h404,      32'hFFFFFFFF, 32'd1,        32'd8,        5'd0, 1'b0, 32'h404,      1'b0, 1'b0, 5'd0, 32'h404,      1'b1, 2'd0};
    vt[5] = '{4'd9,  32'h500,      32'h4F0,      32'd7,        32'd7,        32'hFFFFFFFC, 5'd0, 1'b1, 32'h4F0,      1'b0, 1'b0, 5'd0, 32'h504,      1'b1, 2'd0};
    vt[6] = '{4'd3,  32'h600,      32'h0,        32'd0,        32'h1000,     32'h10,       5'd1, 1'b1, 32'h1040,     1'b1, 1'b1, 5'd1, 32'h604,      1'b1, 2'd2};
    vt[7] = '{4'd0,  32'h700,      32'h704,      32'd1,        32'd2,        32'd3,        5'd4, 1'b0, 32'h704,      1'b0, 1'b0, 5'd0, 32'h704,      1'b0, 2'd0};
    vt[8] = '{4'd4,  32'hFFFFFFF8, 32'h0,        32'd0,        32'd0,        32'd4,        5'd0, 1'b1, 32'h8,        1'b1, 1'b0, 5'd0, 32'hFFFFFFFC, 1'b1, 2'd1};
    vt[9] = '{4'd7,  32'h900,      32'h914,      32'd3,        32'd3,        32'd5,        5'd0, 1'b0, 32'h904,      1'b1, 1'b0, 5'd0, 32'h904,      1'b1, 2'd0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("reset_out", {out_valid, out_rd_en, out_rd_addr, out_rd_data, out_taken, out_target, out_flush, out_category}, 128'd0);
    check("reset_upd", {upd_valid, upd_pc, upd_target, upd_taken, upd_kind}, 128'd0);
    check("reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = vt[i].op; in_pc = vt[i].pc; in_pc_next = vt[i].pc_next;
      in_sr0 = vt[i].sr0; in_sr1 = vt[i].sr1; in_imm = vt[i].imm; in_rd = vt[i].rd;
      in_category = i[1:0];
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check($sformatf("vec%0d_out", i),
            {out_valid, out_taken, out_target, out_flush, out_rd_en, out_rd_addr, out_rd_data},
            {1'b1, vt[i].x_taken, vt[i].x_target, vt[i].x_flush, vt[i].x_rd_en, vt[i].x_rd_addr, vt[i].x_rd_data});
      check($sformatf("vec%0d_upd", i), {upd_valid, upd_kind, upd_pc},
            {vt[i].x_push, vt[i].x_push ? vt[i].x_kind : 2'd0, vt[i].x_push ? vt[i].pc : 32'd0});
    end

    // Fill the queue with the predictor stalled, then drain it.
    @(posedge clk); #1;
    upd_ready = 1'b0; in_valid = 1'b1; in_op = 4'd4;
    for (int k = 0; k < D; k++) begin
      in_pc = 32'h1000 + k * 16; in_imm = k; in_pc_next = 32'h1000 + k * 20;
      @(posedge clk); #1;
    end
    in_pc = 32'h2000;
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; upd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_pop", in_ready, 1'b1);
    repeat (D + 2) @(posedge clk);

    // Kill blocks acceptance and suppresses the output pulse.
    #1 in_valid = 1'b1; in_kill = 1'b1; in_op = 4'd6; in_pc = 32'h40;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("kill_no_out", {out_valid, upd_valid}, 2'b00);

    // Reset with two queued entries, kill asserted at the same time.
    @(posedge clk); #1;
    upd_ready = 1'b0; in_valid = 1'b1; in_op = 4'd5; in_pc = 32'h3000;
    @(posedge clk); #1 in_pc = 32'h3010;
    @(posedge clk); #1 rst = 1'b1; in_kill = 1'b1;
    @(posedge clk); #1 rst = 1'b0; drive_idle(); upd_ready = 1'b1;
    @(negedge clk);
    check("rst_queue", {upd_valid, in_ready, out_valid}, 3'b010);

`ifdef BRANCH_RESOLVE_PERF_EN
    // Three branches, one mispredict.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd6; in_pc = 32'h100; in_sr0 = 32'd1; in_sr1 = 32'd1; in_imm = 32'd4; in_pc_next = 32'h110;
    @(posedge clk); #1 in_op = 4'd4; in_pc = 32'h200; in_imm = 32'd1; in_pc_next = 32'h208;
    @(posedge clk); #1 in_op = 4'd7; in_pc = 32'h300; in_imm = 32'd8; in_pc_next = 32'h304;
    @(posedge clk); #1 drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("perf_counts", {perf_branches, perf_mispredicts}, {32'd3, 32'd1});
`endif

    // Randomized traffic, checked continuously by the model.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kill   = ($urandom_range(0, 9) == 0);
      upd_ready = ($urandom_range(0, 2) != 0);
      in_op     = op_pool[$urandom_range(0, 10)];
      in_rd     = 5'($urandom_range(0, 3));
      in_pc     = {$urandom(), 2'b00} >> 2 << 2;
      in_sr0    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 7));
      in_sr1    = ($urandom_range(0, 2) == 0) ? in_sr0 : (($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 7)));
      in_imm    = 32'($signed(32'($urandom_range(0, 64))) - 32);
      in_category = 2'($urandom_range(0, 3));
      mr = ref_resolve(in_op, in_pc, in_rd, in_sr0, in_sr1, in_imm);
      in_pc_next = ($urandom_range(0, 1) == 0) ? mr.target : in_pc + 32'd4;
    end
    @(posedge clk); #1 rst = 1'b0; drive_idle(); upd_ready = 1'b1;
    repeat (D + 3) @(posedge clk);
    @(negedge clk);
    check("final_drained", {upd_valid, in_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
